// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The burst-lock state StHold is only reachable when FIFO_ARB_BURST_EN is defined.
package fifo_arb_pkg;

  localparam int unsigned MaxReq = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold
  } arb_state_e;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cred_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [MaxReq-1:0] idx_to_oh(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

  function automatic logic [2:0] oh_to_idx(input logic [MaxReq-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping
// modulo N_REQ.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  logic [MaxReq-1:0] oh_full;
  int unsigned       pos;

  // Scan from the farthest offset down so the closest request to rr_ptr wins last.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (32'(rr_ptr) + 32'(k)) % N_REQ;
      if (req[IW'(pos)]) begin
        grant_idx = IW'(pos);
        any       = 1'b1;
      end
    end
    oh_full  = idx_to_oh(3'(grant_idx));
    grant_oh = any ? oh_full[N_REQ-1:0] : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers, with a credit
// counter mirroring FIFO occupancy. Optional burst lock enabled by FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned CW = cred_width(FIFO_DEPTH),
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  input  logic                fifo_full,
  input  logic                fifo_rd,
  output logic                fifo_wn,
  output logic [DW-1:0]       fifo_data,
  output logic [CW-1:0]       credits
);

  if (N_REQ < 2 || N_REQ > MaxReq || MAX_BURST < 1) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          fifo_wn_q, fifo_wn_d;
  logic [DW-1:0] fifo_data_q, fifo_data_d;
  logic [CW-1:0] credits_q, credits_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [N_REQ-1:0] sel_oh;
  logic [IW-1:0]    sel_idx;
  logic             sel_any;
  logic             eligible;
  logic             grant;

  fifo_arb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  logic [IW-1:0]     lock_q, lock_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              lock_hit;
  logic [MaxReq-1:0] lock_oh;

  assign lock_hit = (state_q == StHold) && req[lock_q];
  assign lock_oh  = idx_to_oh(3'(lock_q));
`endif

  // A same-cycle fifo_rd is deliberately not part of eligibility.
  assign eligible = (credits_q != '0) && !fifo_full;

  always_comb begin
    sel_oh  = pick_oh;
    sel_idx = pick_idx;
    sel_any = pick_any;
`ifdef FIFO_ARB_BURST_EN
    if (lock_hit) begin
      sel_oh  = lock_oh[N_REQ-1:0];
      sel_idx = lock_q;
      sel_any = 1'b1;
    end
`endif
    grant = sel_any && eligible;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StIssue: begin
        if (!grant) begin
          state_d = StIdle;
`ifdef FIFO_ARB_BURST_EN
        end else if (MAX_BURST > 1) begin
          state_d = StHold;
`endif
        end else begin
          state_d = StIssue;
        end
      end
`ifdef FIFO_ARB_BURST_EN
      StHold: begin
        if (lock_hit) begin
          // A credit stall keeps the lock; the final word of a burst releases it.
          if (grant && (32'(burst_cnt_q) + 1 >= MAX_BURST)) state_d = StIssue;
          else                                              state_d = StHold;
        end else if (grant) begin
          state_d = (MAX_BURST > 1) ? StHold : StIssue;
        end else begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: ack is combinational and suppressed during reset.
  always_comb begin
    ack = '0;
    if (grant && reset) ack = sel_oh;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    fifo_wn_d   = grant;
    fifo_data_d = fifo_data_q;
    if (grant) begin
      rr_ptr_d    = IW'((32'(sel_idx) + 1) % N_REQ);
      fifo_data_d = req_data[32'(sel_idx) * DW +: DW];
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (grant && !fifo_rd) begin
      credits_d = credits_q - CW'(1);
    end else if (fifo_rd && !grant && (credits_q != CW'(FIFO_DEPTH))) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      fifo_wn_q   <= 1'b0;
      fifo_data_q <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      fifo_wn_q   <= fifo_wn_d;
      fifo_data_q <= fifo_data_d;
      credits_q   <= credits_d;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_comb begin
    lock_d      = lock_q;
    burst_cnt_d = burst_cnt_q;
    if (grant) begin
      if (lock_hit) begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end else begin
        lock_d      = sel_idx;
        burst_cnt_d = BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q      <= '0;
      burst_cnt_q <= '0;
    end else begin
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

  assign fifo_wn   = fifo_wn_q;
  assign fifo_data = fifo_data_q;
  assign credits   = credits_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration and credit rules.
module tb_fifo_wr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MB    = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      ack;
  logic              fifo_full = 1'b0;
  logic              fifo_rd = 1'b0;
  logic              fifo_wn;
  logic [DW-1:0]     fifo_data;
  logic [CW-1:0]     credits;

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DW         (DW),
    .FIFO_DEPTH (DEPTH),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_rd   (fifo_rd),
    .fifo_wn   (fifo_wn),
    .fifo_data (fifo_data),
    .credits   (credits)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected registered outputs and arbitration history.
  int            m_credits;
  int            m_rr;
  int            m_lock;
  int            m_cnt;
  logic          m_wn;
  logic [DW-1:0] m_data;
  int            last_g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] r, input logic elig, input int rr);
    int g;
    g = -1;
    if (elig) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && r[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_credits = DEPTH;
    m_rr      = 0;
    m_lock    = -1;
    m_cnt     = 0;
    m_wn      = 1'b0;
    m_data    = '0;
    last_g    = -1;
  endtask

  // Called at posedge+1; checks at negedge, then advances to the next posedge+1.
  task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic full,
                      input logic rd);
    int           g;
    logic         elig;
    logic [N-1:0] exp_ack;
    req       = r;
    req_data  = d;
    fifo_full = full;
    fifo_rd   = rd;
    #4;
    check_eq("fifo_wn", 32'(fifo_wn), 32'(m_wn));
    check_eq("fifo_data", 32'(fifo_data), 32'(m_data));
    check_eq("credits", 32'(credits), 32'(m_credits));
    elig = (m_credits != 0) && !full;
`ifdef FIFO_ARB_BURST_EN
    g = -1;
    if (m_lock >= 0 && r[m_lock]) begin
      if (elig) begin
        g = m_lock;
        m_cnt++;
        if (m_cnt >= MB) m_lock = -1;
      end
    end else begin
      m_lock = -1;
      g = rr_model(r, elig, m_rr);
      if (g >= 0 && MB > 1) begin
        m_lock = g;
        m_cnt  = 1;
      end
    end
`else
    g = rr_model(r, elig, m_rr);
`endif
    exp_ack = (g >= 0) ? N'(1) << g : '0;
    check_eq("ack", 32'(ack), 32'(exp_ack));
    last_g = g;
    m_wn   = (g >= 0);
    if (g >= 0) begin
      m_data = d[g*DW +: DW];
      m_rr   = (g + 1) % N;
      if (!rd) m_credits--;
    end else if (rd && m_credits < DEPTH) begin
      m_credits++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    reset     = 1'b0;
    req       = r;
    fifo_full = 1'b0;
    fifo_rd   = 1'b0;
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_wn", 32'(fifo_wn), 32'd0);
    check_eq("rst_credits", 32'(credits), 32'(DEPTH));
    check_eq("rst_data", 32'(fifo_data), 32'd0);
    @(posedge clk);
    #1;
    req   = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           cnt;
    logic [N-1:0] pend;
    logic [N*DW-1:0] pdata;
    reset = 1'b1;
    model_reset();
    #2;

    // Reset with all requests high, then a single word from requester 0.
    do_reset(4'hF);
    step(4'b0001, {24'h0, 8'hA5}, 1'b0, 1'b0);
    check_eq("t1_ack_idx", 32'(last_g), 32'd0);
    check_eq("t1_wn", 32'(fifo_wn), 32'd1);
    check_eq("t1_data", 32'(fifo_data), 32'hA5);
    check_eq("t1_credits", 32'(credits), 32'd7);

    // Fairness with all requesters active until credits run out.
    do_reset(4'h0);
    for (int i = 0; i < 10; i++) begin
      step(4'hF, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b0, 1'b0);
      check_eq("fair_seq", 32'(last_g), (i < 8) ? 32'(i % 4) : 32'hFFFF_FFFF);
    end

    // Credit stall: nine words offered, eight accepted, ninth after one read.
    do_reset(4'h0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b0001, {24'h0, 8'(8'h30 + cnt)}, 1'b0, 1'b0);
      if (last_g == 0) cnt++;
    end
    check_eq("stall_acks", 32'(cnt), 32'd8);
    step(4'b0001, {24'h0, 8'h38}, 1'b0, 1'b1);
    check_eq("rd_same_cycle", 32'(last_g), 32'hFFFF_FFFF);
    step(4'b0001, {24'h0, 8'h38}, 1'b0, 1'b0);
    check_eq("ninth_ack", 32'(last_g), 32'd0);
    step(4'b0000, '0, 1'b0, 1'b0);

    // Grant and read together at credits=3; read at full credit saturates.
    do_reset(4'h0);
    for (int i = 0; i < 5; i++) step(4'b0010, {16'h0, 8'h50 + 8'(i), 8'h0}, 1'b0, 1'b0);
    check_eq("cred_at3", 32'(credits), 32'd3);
    step(4'b0010, {16'h0, 8'h55, 8'h0}, 1'b0, 1'b1);
    check_eq("grant_rd_hold", 32'(credits), 32'd3);
    do_reset(4'h0);
    step(4'b0000, '0, 1'b0, 1'b1);
    check_eq("rd_sat", 32'(credits), 32'(DEPTH));

    // FIFO full blocks grants; reset while a write is in flight.
    do_reset(4'h0);
    step(4'hF, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1, 1'b0);
    check_eq("full_no_ack", 32'(last_g), 32'hFFFF_FFFF);
    step(4'hF, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 1'b0);
    check_eq("wn_inflight", 32'(fifo_wn), 32'd1);
    do_reset(4'hF);

    // Randomized traffic; requesters hold word until acked.
    pend  = '0;
    pdata = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]           = 1'b1;
          pdata[i*DW +: DW] = 8'($urandom);
        end
      end
      step(pend, pdata, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

`ifdef FIFO_ARB_BURST_EN
    do_reset(4'h0);
    for (int i = 0; i < 8; i++) begin
      step(4'b0011, {16'h0, 8'hB0 + 8'(i), 8'hA0 + 8'(i)}, 1'b0, 1'b1);
      check_eq("burst_seq", 32'(last_g), (i < 4) ? 32'd0 : 32'd1);
    end
    do_reset(4'h0);
    step(4'b0011, {16'h0, 8'hB0, 8'hA0}, 1'b0, 1'b0);
    step(4'b0011, {16'h0, 8'hB0, 8'hA1}, 1'b0, 1'b0);
    step(4'b0010, {16'h0, 8'hB0, 8'h00}, 1'b0, 1'b0);
    check_eq("burst_drop", 32'(last_g), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
